// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - commit-event trace buffer with halt/drain FSM; optional COMMIT_TRACE_CYCLE_EN adds cycle timestamps
module commit_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev_valid,
  input  logic [DATA_W-1:0] ev_pc,
  input  logic [DATA_W-1:0] ev_inst,
  input  logic              ev_regwrite,
  input  logic [REG_W-1:0]  ev_wreg,
  input  logic [DATA_W-1:0] ev_wdata,
  input  logic              ev_memread,
  input  logic              ev_memwrite,
  input  logic [DATA_W-1:0] ev_maddr,
  input  logic [DATA_W-1:0] ev_mdata,
  input  logic              ev_halt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [2:0]        rd_kind,
  output logic [CNT_W-1:0]  rd_inum,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_wdata,
  output logic [DATA_W-1:0] rd_maddr,
  output logic [DATA_W-1:0] rd_mdata,
  output logic [REG_W-1:0]  rd_wreg,
`ifdef COMMIT_TRACE_CYCLE_EN
  output logic [CNT_W-1:0]  rd_cycle,
  output logic [CNT_W-1:0]  cycle_count,
`endif
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              halted,
  output logic              drained
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [2:0] KIND_REG   = 3'd0;
  localparam logic [2:0] KIND_LOAD  = 3'd1;
  localparam logic [2:0] KIND_STU   = 3'd2;
  localparam logic [2:0] KIND_STORE = 3'd3;
  localparam logic [2:0] KIND_NOP   = 3'd4;
  localparam logic [2:0] KIND_HALT  = 3'd5;

  typedef enum logic [1:0] {CAPTURE, HALTED, DRAINED} traceState;

  traceState state;

  logic [2:0]        kindMem  [DEPTH];
  logic [CNT_W-1:0]  inumMem  [DEPTH];
  logic [DATA_W-1:0] pcMem    [DEPTH];
  logic [REG_W-1:0]  wregMem  [DEPTH];
  logic [DATA_W-1:0] wdataMem [DEPTH];
  logic [DATA_W-1:0] maddrMem [DEPTH];
  logic [DATA_W-1:0] mdataMem [DEPTH];

  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   countNext;
  logic [CNT_W-1:0] instCount;
  logic [CNT_W-1:0] dropCount;
  logic             overflowFlag;
  logic             haltedFlag;
  logic             drainedFlag;
  logic [2:0]       evKind;

  logic rdValid;
  logic isFull;
  logic capture;
  logic pop;
  logic push;
  logic overwrite;
  logic dropEv;
  logic headAdvance;
  logic unusedInst;

  // The instruction word is accepted for interface compatibility but not recorded.
  assign unusedInst = ^ev_inst;

  assign rdValid     = (count != '0);
  assign isFull      = (count == FULL_CNT);
  assign capture     = (state == CAPTURE) && ev_valid;
  assign pop         = rdValid && rd_ready;
  // Halts always get a slot; a full buffer with no pop sacrifices its oldest record.
  assign push        = capture && (ev_halt || !isFull || pop);
  assign overwrite   = capture && ev_halt && isFull && !pop;
  assign dropEv      = capture && isFull && !pop;
  assign headAdvance = pop || overwrite;

  // Classify the incoming event by priority.
  always_comb begin
    evKind = KIND_NOP;
    if (ev_halt)                         evKind = KIND_HALT;
    else if (ev_regwrite && ev_memwrite) evKind = KIND_STU;
    else if (ev_regwrite && ev_memread)  evKind = KIND_LOAD;
    else if (ev_regwrite)                evKind = KIND_REG;
    else if (ev_memwrite)                evKind = KIND_STORE;
  end

  // Occupancy update from push and head-advance.
  always_comb begin
    countNext = count;
    case ({push, headAdvance})
      2'b10:   countNext = count + (PTR_W+1)'(1);
      2'b01:   countNext = count - (PTR_W+1)'(1);
      default: countNext = count;
    endcase
  end

  // Record storage; only ever read through the valid-gated head outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      kindMem[tailPtr]  <= evKind;
      inumMem[tailPtr]  <= instCount;
      pcMem[tailPtr]    <= ev_pc;
      wregMem[tailPtr]  <= ev_wreg;
      wdataMem[tailPtr] <= ev_wdata;
      maddrMem[tailPtr] <= ev_maddr;
      mdataMem[tailPtr] <= ev_mdata;
    end
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push)        tailPtr <= tailPtr + PTR_W'(1);
      if (headAdvance) headPtr <= headPtr + PTR_W'(1);
      count <= countNext;
    end
  end

  // Event and drop accounting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instCount    <= '0;
      dropCount    <= '0;
      overflowFlag <= 1'b0;
    end else begin
      if (capture) instCount <= instCount + CNT_W'(1);
      if (dropEv) begin
        dropCount    <= dropCount + CNT_W'(1);
        overflowFlag <= 1'b1;
      end
    end
  end

  // Capture/halt/drain state machine with registered status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= CAPTURE;
      haltedFlag  <= 1'b0;
      drainedFlag <= 1'b0;
    end else begin
      case (state)
        CAPTURE: if (capture && ev_halt) begin
          state      <= HALTED;
          haltedFlag <= 1'b1;
        end
        HALTED: if (countNext == '0) begin
          state       <= DRAINED;
          drainedFlag <= 1'b1;
        end
        default: state <= DRAINED;
      endcase
    end
  end

`ifdef COMMIT_TRACE_CYCLE_EN
  logic [CNT_W-1:0] cycleCount;
  logic [CNT_W-1:0] cycleMem [DEPTH];

  // Free-running cycle counter that freezes once the trace is fully drained.
  always_ff @(posedge clk) begin
    if (!rst)                  cycleCount <= '0;
    else if (state != DRAINED) cycleCount <= cycleCount + CNT_W'(1);
  end

  // Timestamp each stored record with the cycle counter at push.
  always_ff @(posedge clk) begin
    if (push) cycleMem[tailPtr] <= cycleCount;
  end

  assign rd_cycle    = rdValid ? cycleMem[headPtr] : '0;
  assign cycle_count = cycleCount;
`endif

  assign rd_valid   = rdValid;
  assign rd_kind    = rdValid ? kindMem[headPtr]  : '0;
  assign rd_inum    = rdValid ? inumMem[headPtr]  : '0;
  assign rd_pc      = rdValid ? pcMem[headPtr]    : '0;
  assign rd_wreg    = rdValid ? wregMem[headPtr]  : '0;
  assign rd_wdata   = rdValid ? wdataMem[headPtr] : '0;
  assign rd_maddr   = rdValid ? maddrMem[headPtr] : '0;
  assign rd_mdata   = rdValid ? mdataMem[headPtr] : '0;
  assign inst_count = instCount;
  assign drop_count = dropCount;
  assign overflow   = overflowFlag;
  assign halted     = haltedFlag;
  assign drained    = drainedFlag;

endmodule
